// File: rtl/lift_pkg.sv
// Shared encodings for the SCAN lift controller: request kinds, motion codes,
// FSM states and travel direction.
package lift_pkg;

    typedef enum logic [1:0] {
        KIND_CAR  = 2'b00,
        KIND_UP   = 2'b01,
        KIND_DOWN = 2'b10,
        KIND_RSVD = 2'b11
    } req_kind_t;

    typedef enum logic [1:0] {
        MOT_UP   = 2'b00,
        MOT_DOWN = 2'b01,
        MOT_STAY = 2'b10
    } motion_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_DOOR
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/lift_call_reg.sv
// Up, down and car call vectors with set/clear, plus the floor-relative
// reduction flags the SCAN controller decides on.
module lift_call_reg
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [1:0]            set_kind,
    input  logic [FLOOR_W-1:0]    set_floor,
    input  logic                  clr_en,
    input  logic [FLOOR_W-1:0]    clr_floor,
    input  logic                  clr_dir,
    input  logic                  clr_opp,
    input  logic [FLOOR_W-1:0]    q_floor,
    input  logic                  q_dir,
    output logic                  car_at,
    output logic                  same_at,
    output logic                  opp_at,
    output logic                  ahead,
    output logic                  behind,
    output logic [NUM_FLOORS-1:0] pending
);

    logic [NUM_FLOORS-1:0] car_q, up_q, dn_q;
    logic [NUM_FLOORS-1:0] set_car, set_up, set_dn;
    logic [NUM_FLOORS-1:0] clr_car, clr_up, clr_dn;
    logic [NUM_FLOORS-1:0] above_m, below_m, at_m;

    always_comb begin
        set_car = '0;
        set_up  = '0;
        set_dn  = '0;
        clr_car = '0;
        clr_up  = '0;
        clr_dn  = '0;
        above_m = '0;
        below_m = '0;
        at_m    = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (set_en && int'(set_floor) == i) begin
                set_car[i] = (set_kind == KIND_CAR);
                set_up[i]  = (set_kind == KIND_UP);
                set_dn[i]  = (set_kind == KIND_DOWN);
            end
            if (clr_en && int'(clr_floor) == i) begin
                clr_car[i] = 1'b1;
                clr_up[i]  = (clr_dir == DIR_UP) || clr_opp;
                clr_dn[i]  = (clr_dir == DIR_DOWN) || clr_opp;
            end
            above_m[i] = (i > int'(q_floor));
            below_m[i] = (i < int'(q_floor));
            at_m[i]    = (i == int'(q_floor));
        end
    end

    // Clear is applied after set so a serviced bit cannot be re-latched on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            car_q <= '0;
            up_q  <= '0;
            dn_q  <= '0;
        end else begin
            car_q <= (car_q | set_car) & ~clr_car;
            up_q  <= (up_q  | set_up)  & ~clr_up;
            dn_q  <= (dn_q  | set_dn)  & ~clr_dn;
        end
    end

    assign pending = car_q | up_q | dn_q;
    assign car_at  = |(car_q & at_m);
    assign same_at = |(((q_dir == DIR_UP) ? up_q : dn_q) & at_m);
    assign opp_at  = |(((q_dir == DIR_UP) ? dn_q : up_q) & at_m);
    assign ahead   = |(pending & ((q_dir == DIR_UP) ? above_m : below_m));
    assign behind  = |(pending & ((q_dir == DIR_UP) ? below_m : above_m));

endmodule

// File: rtl/lift_scan_ctrl.sv
// N-floor SCAN elevator controller: latches calls, sweeps in one direction
// while calls lie ahead, and times travel per floor and door dwell.
//   state | meaning
//   IDLE  | parked, door closed, waiting for a call
//   MOVE  | travelling one floor per TRAVEL_CYC cycles in dir
//   DOOR  | door open at cur_floor for DOOR_CYC cycles
module lift_scan_ctrl
    import lift_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS),
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FLOOR_W-1:0]    req_floor,
    input  logic [1:0]            req_kind,
    output logic                  req_err,
    output logic [1:0]            dout,
    output logic [FLOOR_W-1:0]    cur_floor,
    output logic                  door_open,
    output logic                  idle,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYC - 1);

    state_t             state_q, state_d;
    logic               dir_q, dir_d;
    logic [FLOOR_W-1:0] floor_q, floor_d, step_floor, q_floor;
    logic [TW-1:0]      tcnt_q, tcnt_d;
    logic [DW-1:0]      dcnt_q, dcnt_d;
    logic               err_q;
    logic               req_bad, req_hit, set_en, clr_en, clr_opp;
    logic               last_step, at_edge, stop;
    logic               car_at, same_at, opp_at, ahead, behind;

    assign req_bad = req_valid &&
                     (int'(req_floor) >= NUM_FLOORS || req_kind == KIND_RSVD ||
                      (req_kind == KIND_UP && int'(req_floor) == NUM_FLOORS - 1) ||
                      (req_kind == KIND_DOWN && req_floor == '0));

    // A call the open door is already serving only extends the dwell.
    assign req_hit = req_valid && !req_bad && state_q == ST_DOOR && req_floor == floor_q &&
                     (req_kind == KIND_CAR ||
                      (req_kind == KIND_UP && dir_q == DIR_UP) ||
                      (req_kind == KIND_DOWN && dir_q == DIR_DOWN));
    assign set_en  = req_valid && !req_bad && !req_hit;

    assign step_floor = (dir_q == DIR_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
    assign last_step  = (state_q == ST_MOVE) && (tcnt_q == '0);
    assign q_floor    = last_step ? step_floor : floor_q;
    assign at_edge    = (dir_q == DIR_UP) ? (int'(step_floor) == NUM_FLOORS - 1)
                                          : (step_floor == '0);
    assign stop       = car_at || same_at || (!ahead && opp_at) || at_edge;

    lift_call_reg #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_calls (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_en    (set_en),
        .set_kind  (req_kind),
        .set_floor (req_floor),
        .clr_en    (clr_en),
        .clr_floor (q_floor),
        .clr_dir   (dir_q),
        .clr_opp   (clr_opp),
        .q_floor   (q_floor),
        .q_dir     (dir_q),
        .car_at    (car_at),
        .same_at   (same_at),
        .opp_at    (opp_at),
        .ahead     (ahead),
        .behind    (behind),
        .pending   (pending)
    );

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        floor_d = floor_q;
        tcnt_d  = tcnt_q;
        dcnt_d  = dcnt_q;
        clr_en  = 1'b0;
        clr_opp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (car_at || same_at || opp_at) begin
                    state_d = ST_DOOR;
                    dcnt_d  = DOOR_LOAD;
                    clr_en  = 1'b1;
                    clr_opp = !ahead;
                    if (!ahead) dir_d = ~dir_q;
                end else if (ahead || behind) begin
                    state_d = ST_MOVE;
                    tcnt_d  = TRAVEL_LOAD;
                    if (!ahead) dir_d = ~dir_q;
                end
            end
            ST_MOVE: begin
                if (tcnt_q == '0) begin
                    floor_d = step_floor;
                    if (stop) begin
                        state_d = ST_DOOR;
                        dcnt_d  = DOOR_LOAD;
                        clr_en  = 1'b1;
                        clr_opp = !ahead;
                        if (!ahead) dir_d = ~dir_q;
                    end else begin
                        tcnt_d = TRAVEL_LOAD;
                    end
                end else begin
                    tcnt_d = tcnt_q - TW'(1);
                end
            end
            ST_DOOR: begin
                if (req_hit) begin
                    dcnt_d = DOOR_LOAD;
                end else if (dcnt_q == '0) begin
                    if (ahead) begin
                        state_d = ST_MOVE;
                        tcnt_d  = TRAVEL_LOAD;
                    end else if (behind) begin
                        state_d = ST_MOVE;
                        tcnt_d  = TRAVEL_LOAD;
                        dir_d   = ~dir_q;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    dcnt_d = dcnt_q - DW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dir_q   <= DIR_UP;
            floor_q <= '0;
            tcnt_q  <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            floor_q <= floor_d;
            tcnt_q  <= tcnt_d;
            dcnt_q  <= dcnt_d;
            err_q   <= req_bad;
        end
    end

    assign req_ready = 1'b1;
    assign req_err   = err_q;
    assign cur_floor = floor_q;
    assign door_open = (state_q == ST_DOOR);
    assign idle      = (state_q == ST_IDLE) && (pending == '0);
    assign dout      = (state_q != ST_MOVE) ? MOT_STAY : ((dir_q == DIR_UP) ? MOT_UP : MOT_DOWN);

endmodule

// File: tb/tb_lift_scan_ctrl.sv
// Bench for lift_scan_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a floor/call-list model of SCAN servicing.
module tb_lift_scan_ctrl;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int TC = 4;
    localparam int DC = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [FW-1:0] req_floor = '0;
    logic [1:0]    req_kind = '0;
    logic          req_err;
    logic [1:0]    dout;
    logic [FW-1:0] cur_floor;
    logic          door_open;
    logic          idle;
    logic [NF-1:0] pending;

    // five-floor instance so an unrepresentable-free out-of-range floor can be sent
    logic          v5 = 1'b0;
    logic          rdy5;
    logic [2:0]    f5 = '0;
    logic [1:0]    k5 = '0;
    logic          err5;
    logic [1:0]    dout5;
    logic [2:0]    floor5;
    logic          door5;
    logic          idle5;
    logic [4:0]    pend5;

    always #5 clk = ~clk;

    lift_scan_ctrl #(.NUM_FLOORS(NF), .TRAVEL_CYC(TC), .DOOR_CYC(DC)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_floor(req_floor), .req_kind(req_kind), .req_err(req_err), .dout(dout),
        .cur_floor(cur_floor), .door_open(door_open), .idle(idle), .pending(pending)
    );

    lift_scan_ctrl #(.NUM_FLOORS(5), .TRAVEL_CYC(2), .DOOR_CYC(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .req_valid(v5), .req_ready(rdy5),
        .req_floor(f5), .req_kind(k5), .req_err(err5), .dout(dout5),
        .cur_floor(floor5), .door_open(door5), .idle(idle5), .pending(pend5)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 parked, 1 travelling, 2 door open; dir 0 up, 1 down.
    bit m_car[NF];
    bit m_up[NF];
    bit m_dn[NF];
    int m_floor, m_dir, m_mode, m_travel, m_door;
    bit m_err;

    function automatic bit any_at(int f);
        return m_car[f] || m_up[f] || m_dn[f];
    endfunction

    function automatic bit beyond(int f, int d);
        for (int i = 0; i < NF; i++)
            if (any_at(i) && ((d == 0 && i > f) || (d == 1 && i < f))) return 1;
        return 0;
    endfunction

    function automatic bit stops_at(int f, int d);
        bit same = (d == 0) ? m_up[f] : m_dn[f];
        bit opp  = (d == 0) ? m_dn[f] : m_up[f];
        return m_car[f] || same || (!beyond(f, d) && opp) ||
               (d == 0 && f == NF - 1) || (d == 1 && f == 0);
    endfunction

    function automatic logic [NF-1:0] m_pending();
        logic [NF-1:0] p = '0;
        for (int i = 0; i < NF; i++) p[i] = any_at(i);
        return p;
    endfunction

    task automatic model_tick(input bit r, input bit v, input int f, input int k);
        bit legal, absorb, srv, opp_clr, err_n;
        int sf, sd;
        if (!r) begin
            for (int i = 0; i < NF; i++) begin
                m_car[i] = 0; m_up[i] = 0; m_dn[i] = 0;
            end
            m_floor = 0; m_dir = 0; m_mode = 0; m_travel = 0; m_door = 0; m_err = 0;
            return;
        end
        legal  = v && f < NF && k != 3 && !(k == 1 && f == NF - 1) && !(k == 2 && f == 0);
        err_n  = v && !legal;
        absorb = legal && m_mode == 2 && f == m_floor && (k == 0 || k == 1 + m_dir);
        srv = 0;
        sf = 0; sd = 0; opp_clr = 0;
        case (m_mode)
            0: begin
                if (any_at(m_floor)) srv = 1;
                else if (beyond(m_floor, m_dir) || beyond(m_floor, 1 - m_dir)) begin
                    if (!beyond(m_floor, m_dir)) m_dir = 1 - m_dir;
                    m_mode = 1; m_travel = 0;
                end
            end
            1: begin
                m_travel++;
                if (m_travel == TC) begin
                    m_floor += (m_dir == 0) ? 1 : -1;
                    m_travel = 0;
                    if (stops_at(m_floor, m_dir)) srv = 1;
                end
            end
            default: begin
                if (absorb) m_door = 0;
                else begin
                    m_door++;
                    if (m_door == DC) begin
                        if (beyond(m_floor, m_dir)) begin
                            m_mode = 1; m_travel = 0;
                        end else if (beyond(m_floor, 1 - m_dir)) begin
                            m_dir = 1 - m_dir; m_mode = 1; m_travel = 0;
                        end else m_mode = 0;
                    end
                end
            end
        endcase
        if (srv) begin
            sf = m_floor; sd = m_dir;
            opp_clr = !beyond(sf, sd);
            if (opp_clr) m_dir = 1 - m_dir;
            m_mode = 2; m_door = 0;
        end
        if (legal && !absorb) begin
            if (k == 0) m_car[f] = 1;
            else if (k == 1) m_up[f] = 1;
            else m_dn[f] = 1;
        end
        if (srv) begin
            m_car[sf] = 0;
            if (sd == 0 || opp_clr) m_up[sf] = 0;
            if (sd == 1 || opp_clr) m_dn[sf] = 0;
        end
        m_err = err_n;
    endtask

    task automatic tick(input bit r, input bit v, input int f, input int k);
        rst_n     = r;
        req_valid = v;
        req_floor = f[FW-1:0];
        req_kind  = k[1:0];
        @(posedge clk);
        model_tick(r, v, f, k);
        #1;
        rst_n     = 1'b1;
        req_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("dout", int'(dout), (m_mode == 1) ? m_dir : 2);
            check("cur_floor", int'(cur_floor), m_floor);
            check("door_open", int'(door_open), int'(m_mode == 2));
            check("idle", int'(idle), int'(m_mode == 0 && m_pending() == '0));
            check("pending", int'(pending), int'(m_pending()));
            check("req_err", int'(req_err), int'(m_err));
            check("req_ready", int'(req_ready), 1);
        end
    end

    int n_up, n_door, rf, rk;
    bit saw, reached, rv, rr;
    int stops[$];
    bit prev_door;

    initial begin
        // 1: reset
        tick(0, 0, 0, 0);
        chk_on = 1;
        tick(1, 0, 0, 0);
        check("t1_floor", int'(cur_floor), 0);
        check("t1_dout", int'(dout), 2);
        check("t1_door", int'(door_open), 0);
        check("t1_idle", int'(idle), 1);
        check("t1_pending", int'(pending), 0);

        // 2: single trip to floor 3
        tick(1, 1, 3, 0);
        n_up = 0;
        for (int c = 0; c < 40; c++) begin
            if (door_open) break;
            if (dout == 2'b00) n_up++;
            tick(1, 0, 0, 0);
        end
        check("t2_up_cycles", n_up, 12);
        check("t2_floor", int'(cur_floor), 3);
        n_door = 0;
        for (int c = 0; c < 20; c++) begin
            if (!door_open) break;
            n_door++;
            tick(1, 0, 0, 0);
        end
        check("t2_door_cycles", n_door, 3);
        check("t2_idle", int'(idle), 1);
        check("t2_pending", int'(pending), 0);

        // 3: SCAN ordering (car 5 then hall down 2 on consecutive edges)
        tick(0, 0, 0, 0);
        tick(1, 1, 5, 0);
        tick(1, 1, 2, 2);
        stops.delete();
        saw = 0;
        prev_door = 0;
        for (int c = 0; c < 200; c++) begin
            if (door_open && !prev_door) stops.push_back(int'(cur_floor));
            if (dout == 2'b01) saw = 1;
            prev_door = door_open;
            if (idle) break;
            tick(1, 0, 0, 0);
        end
        check("t3_nstops", stops.size(), 2);
        if (stops.size() == 2) begin
            check("t3_stop0", stops[0], 5);
            check("t3_stop1", stops[1], 2);
        end
        check("t3_went_down", int'(saw), 1);
        check("t3_idle", int'(idle), 1);

        // 4: hall up at current floor
        tick(0, 0, 0, 0);
        tick(1, 1, 0, 1);
        check("t4_door_early", int'(door_open), 0);
        check("t4_pend", int'(pending), 1);
        tick(1, 0, 0, 0);
        check("t4_door_open", int'(door_open), 1);
        n_door = 1;
        saw = 0;
        for (int c = 0; c < 20; c++) begin
            tick(1, 0, 0, 0);
            if (dout == 2'b00) saw = 1;
            if (!door_open) break;
            n_door++;
        end
        check("t4_door_cycles", n_door, 3);
        check("t4_no_up", int'(saw), 0);
        check("t4_idle", int'(idle), 1);

        // 5: illegal requests
        tick(0, 0, 0, 0);
        tick(1, 1, 3, 3);
        check("t5_err_rsvd", int'(req_err), 1);
        tick(1, 0, 0, 0);
        check("t5_err_clear", int'(req_err), 0);
        tick(1, 1, 7, 1);
        check("t5_err_top_up", int'(req_err), 1);
        tick(1, 1, 0, 2);
        check("t5_err_bot_dn", int'(req_err), 1);
        tick(1, 0, 0, 0);
        check("t5_err_end", int'(req_err), 0);
        check("t5_pending", int'(pending), 0);
        v5 = 1; f5 = 3'd6; k5 = 2'b00;
        tick(1, 0, 0, 0);
        check("t5_n5_err_range", int'(err5), 1);
        check("t5_n5_pend", int'(pend5), 0);
        f5 = 3'd4; k5 = 2'b01;
        tick(1, 0, 0, 0);
        check("t5_n5_err_top", int'(err5), 1);
        f5 = 3'd4; k5 = 2'b00;
        tick(1, 0, 0, 0);
        v5 = 0;
        check("t5_n5_err_ok", int'(err5), 0);
        check("t5_n5_pend_ok", int'(pend5), 16);

        // 6: reset mid-move, timers restart from scratch
        tick(0, 0, 0, 0);
        tick(1, 1, 5, 0);
        reached = 0;
        for (int c = 0; c < 40; c++) begin
            if (cur_floor == 3'd2 && dout == 2'b00) begin
                reached = 1;
                break;
            end
            tick(1, 0, 0, 0);
        end
        check("t6_reached", int'(reached), 1);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        check("t6_floor", int'(cur_floor), 0);
        check("t6_dout", int'(dout), 2);
        check("t6_pending", int'(pending), 0);
        tick(1, 1, 1, 0);
        n_up = 0;
        for (int c = 0; c < 20; c++) begin
            if (door_open) break;
            if (dout == 2'b00) n_up++;
            tick(1, 0, 0, 0);
        end
        check("t6_up_cycles", n_up, 4);

        // random traffic against the model
        tick(0, 0, 0, 0);
        for (int c = 0; c < 4000; c++) begin
            rr = ($urandom_range(0, 599) != 0);
            rv = ($urandom_range(0, 4) == 0);
            rf = ($urandom_range(0, 3) == 0) ? m_floor : int'($urandom_range(0, NF - 1));
            rk = int'($urandom_range(0, 3));
            tick(rr, rv, rf, rk);
        end
        tick(1, 0, 0, 0);
        chk_on = 0;
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
